uart_tx_controller: RTL and testbench

UART transmit sequencer sitting between the host-side write interface and the baud-rate tick generator. It owns the baud configuration (drives the generator's `baud_select`, changing it only between frames), consumes the 16x-oversample `sample_enable` tick, and serializes one frame per write: start, data LSB-first, optional even parity, stop. It exposes a busy/done handshake to the host.

---
 rtl/uart_tx_controller.sv | 117 +++++++++++
 tb/tb_uart_tx_controller.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_controller.sv
// uart_tx_controller: serializes one UART frame per host write using the 16x oversample tick.
//   clk, reset       : rising-edge clock, asynchronous active-high reset
//   tx_en            : gates acceptance of new writes (a running frame always completes)
//   baud_select_in   : requested baud code
//   baud_select_out  : registered baud code to the tick generator, frozen while a frame runs
//   sample_enable    : oversample tick, OVERSAMPLE ticks per bit
//   tx_data, tx_wr   : frame data and level-sampled write strobe
//   tx_busy, tx_done : busy from acceptance to frame end, one-clk completion pulse
//   txd              : registered serial line, idle high
module uart_tx_controller #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter bit PARITY_EN  = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tx_en,
    input  logic [2:0]           baud_select_in,
    output logic [2:0]           baud_select_out,
    input  logic                 sample_enable,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_wr,
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic                 txd
);
    localparam int CW = OVERSAMPLE > 1 ? $clog2(OVERSAMPLE) : 1;
    localparam int BW = DATA_BITS > 1 ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {IDLE, ALIGN, START, DATA, PARITY, STOP} state_t;

    state_t               state, state_d;
    logic [DATA_BITS-1:0] shift, shift_d;
    logic [CW-1:0]        cnt, cnt_d;
    logic [BW-1:0]        bit_idx, bit_d;
    logic [2:0]           baud_d;
    logic                 par, par_d, busy_d, done_d, txd_d, boundary;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            shift           <= '0;
            cnt             <= '0;
            bit_idx         <= '0;
            par             <= 1'b0;
            tx_busy         <= 1'b0;
            tx_done         <= 1'b0;
            txd             <= 1'b1;
            baud_select_out <= 3'b000;
        end else begin
            state           <= state_d;
            shift           <= shift_d;
            cnt             <= cnt_d;
            bit_idx         <= bit_d;
            par             <= par_d;
            tx_busy         <= busy_d;
            tx_done         <= done_d;
            txd             <= txd_d;
            baud_select_out <= baud_d;
        end
    end

    always_comb begin
        state_d  = state;
        shift_d  = shift;
        cnt_d    = cnt;
        bit_d    = bit_idx;
        par_d    = par;
        busy_d   = tx_busy;
        done_d   = 1'b0;
        baud_d   = baud_select_out;
        boundary = sample_enable && cnt == CNT_LAST;
        // Only the bit-driving states count ticks; the ALIGN tick is consumed by the transition.
        if (state inside {START, DATA, PARITY, STOP} && sample_enable)
            cnt_d = boundary ? '0 : cnt + CW'(1);
        case (state)
            IDLE: begin
                baud_d = baud_select_in;
                if (tx_wr && tx_en) begin
                    state_d = ALIGN;
                    shift_d = tx_data;
                    par_d   = ^tx_data;
                    cnt_d   = '0;
                    bit_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            ALIGN:  if (sample_enable) state_d = START;
            START:  if (boundary) state_d = DATA;
            DATA: begin
                if (boundary) begin
                    if (bit_idx == BIT_LAST) begin
                        state_d = PARITY_EN ? PARITY : STOP;
                    end else begin
                        bit_d   = bit_idx + BW'(1);
                        shift_d = shift >> 1;
                    end
                end
            end
            PARITY: if (boundary) state_d = STOP;
            STOP: begin
                if (boundary) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // txd is registered from the next state so each bit appears on the edge that enters it.
        txd_d = state_d == START  ? 1'b0 :
                state_d == DATA   ? shift_d[0] :
                state_d == PARITY ? par_d : 1'b1;
    end
endmodule

// File: tb/tb_uart_tx_controller.sv
// tb_uart_tx_controller: checks a parity and a no-parity transmitter against a frame-level model.
module tb_uart_tx_controller;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tx_en = 1'b0;
    logic       se = 1'b0;
    logic [2:0] baud_in = 3'b000;
    logic       tx_wr [2];
    logic [7:0] tx_data [2];
    logic       txd [2];
    logic       busy [2];
    logic       done [2];
    logic [2:0] bout [2];
    int         tick_period = 4;
    int         tdiv = 0;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    int         fail_prints = 0;

    always #5 clk = ~clk;

    uart_tx_controller dut_p (
        .clk(clk), .reset(reset), .tx_en(tx_en), .baud_select_in(baud_in),
        .baud_select_out(bout[0]), .sample_enable(se), .tx_data(tx_data[0]),
        .tx_wr(tx_wr[0]), .tx_busy(busy[0]), .tx_done(done[0]), .txd(txd[0])
    );

    uart_tx_controller #(.PARITY_EN(1'b0)) dut_np (
        .clk(clk), .reset(reset), .tx_en(tx_en), .baud_select_in(baud_in),
        .baud_select_out(bout[1]), .sample_enable(se), .tx_data(tx_data[1]),
        .tx_wr(tx_wr[1]), .tx_busy(busy[1]), .tx_done(done[1]), .txd(txd[1])
    );

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        forever begin
            @(negedge clk);
            tdiv = (tdiv + 1 >= tick_period) ? 0 : tdiv + 1;
            se = (tick_period == 1) || (tdiv == 0);
        end
    end

    // Frame model: after acceptance wait for a later tick, then bit k of the frame
    // is on the line for ticks n in [16k, 16k+15] counted from that tick.
    int         m_st [2] = '{0, 0};
    int         m_n [2] = '{0, 0};
    int         m_len [2] = '{11, 10};
    logic [10:0] m_bits [2];
    logic       m_txd [2] = '{1'b1, 1'b1};
    logic       m_busy [2] = '{1'b0, 1'b0};
    logic       m_done [2] = '{1'b0, 1'b0};
    logic [2:0] m_baud [2] = '{3'b000, 3'b000};

    always @(posedge clk or posedge reset) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_st[i] = 0; m_n[i] = 0; m_txd[i] = 1'b1;
                m_busy[i] = 1'b0; m_done[i] = 1'b0; m_baud[i] = 3'b000;
            end else begin
                m_done[i] = 1'b0;
                if (m_st[i] == 0) begin
                    m_baud[i] = baud_in;
                    if (tx_wr[i] && tx_en) begin
                        m_bits[i] = (i == 0) ? {1'b1, ^tx_data[i], tx_data[i], 1'b0}
                                             : {2'b11, tx_data[i], 1'b0};
                        m_st[i] = 1;
                        m_busy[i] = 1'b1;
                    end
                end else if (m_st[i] == 1) begin
                    if (se) begin m_st[i] = 2; m_n[i] = 0; end
                end else if (se) begin
                    m_n[i] = m_n[i] + 1;
                    if (m_n[i] == m_len[i] * 16) begin
                        m_st[i] = 0; m_busy[i] = 1'b0; m_done[i] = 1'b1;
                    end
                end
                m_txd[i] = (m_st[i] == 2) ? m_bits[i][m_n[i] / 16] : 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            checks += 4;
            if (txd[i] !== m_txd[i] || busy[i] !== m_busy[i] || done[i] !== m_done[i] || bout[i] !== m_baud[i]) begin
                errors++;
                if (fail_prints < 30) begin
                    fail_prints++;
                    $display("FAIL cycle_compare dut%0d cyc %0d: txd/busy/done/baud got %b/%b/%b/%b expected %b/%b/%b/%b",
                             i, cyc, txd[i], busy[i], done[i], bout[i], m_txd[i], m_busy[i], m_done[i], m_baud[i]);
                end
            end
        end
    end

    // Frame timing monitor: first fall of a frame and each done pulse.
    int   fall_cyc [2] = '{0, 0};
    int   done_cyc [2] = '{0, 0};
    int   done_cnt [2] = '{0, 0};
    logic in_frame [2] = '{1'b0, 1'b0};
    logic prev_txd [2] = '{1'b1, 1'b1};

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                in_frame[i] = 1'b0;
            end else begin
                if (prev_txd[i] && !txd[i] && !in_frame[i]) begin
                    fall_cyc[i] = cyc; in_frame[i] = 1'b1;
                end
                if (done[i]) begin
                    done_cyc[i] = cyc; done_cnt[i]++; in_frame[i] = 1'b0;
                end
            end
            prev_txd[i] = txd[i];
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    task automatic write(input int i, input logic [7:0] d);
        tx_data[i] = d;
        tx_wr[i] = 1'b1;
        step(1);
        tx_wr[i] = 1'b0;
    endtask

    task automatic wait_done(input int i, input int budget);
        int k = 0;
        while (!done[i] && k < budget) begin step(1); k++; end
        checks++;
        if (!done[i]) begin
            errors++;
            $display("FAIL timeout_done dut%0d: no tx_done within %0d clks", i, budget);
        end
    endtask

    task automatic wait_fall(input int i, input int budget);
        int k = 0;
        while (txd[i] && k < budget) begin step(1); k++; end
        checks++;
        if (txd[i]) begin
            errors++;
            $display("FAIL timeout_fall dut%0d: no start bit within %0d clks", i, budget);
        end
    endtask

    initial begin
        logic [10:0] cap;
        int d1, gap;
        tx_wr = '{1'b0, 1'b0};
        tx_data = '{8'h00, 8'h00};
        tx_en = 1'b1;
        #1 reset = 1'b1;
        #1;
        chk("reset_txd", int'(txd[0]), 1);
        chk("reset_busy", int'(busy[0]), 0);
        chk("reset_done", int'(done[0]), 0);
        chk("reset_baud", int'(bout[0]), 0);
        step(3);
        reset = 1'b0;
        step(2);

        // 0xA5 with parity, tick every 4 clks, baud request changes mid-frame
        write(0, 8'hA5);
        wait_fall(0, 100);
        step(32);
        for (int b = 0; b < 11; b++) begin
            cap[b] = txd[0];
            if (b == 3) baud_in = 3'b101;
            if (b < 10) step(64);
        end
        chk("a5_bits", int'(cap), int'(11'b10101001010));
        chk("baud_frozen_mid", int'(bout[0]), 0);
        wait_done(0, 200);
        chk("a5_frame_clks", done_cyc[0] - fall_cyc[0], 704);
        chk("a5_busy_at_done", int'(busy[0]), 0);
        chk("a5_txd_at_done", int'(txd[0]), 1);
        chk("baud_at_done", int'(bout[0]), 0);
        step(1);
        chk("baud_after_idle", int'(bout[0]), 5);
        chk("a5_done_count", done_cnt[0], 1);

        // writes with tx_en low and while busy are dropped; tx_en drop mid-frame lets the frame finish
        tx_en = 1'b0;
        write(0, 8'h55);
        step(100);
        chk("en_low_no_frame", done_cnt[0], 1);
        chk("en_low_busy", int'(busy[0]), 0);
        tx_en = 1'b1;
        write(0, 8'h0F);
        step(20);
        write(0, 8'hF0);
        tx_en = 1'b0;
        wait_done(0, 1000);
        tx_en = 1'b1;
        step(100);
        chk("busy_write_dropped", done_cnt[0], 2);
        chk("idle_after_drop", int'(busy[0]), 0);

        // no-parity instance, back-to-back frames with the second write in the done cycle
        write(1, 8'h00);
        wait_done(1, 1000);
        chk("np00_frame_clks", done_cyc[1] - fall_cyc[1], 640);
        d1 = done_cyc[1];
        write(1, 8'hFF);
        wait_fall(1, 20);
        gap = fall_cyc[1] - d1;
        checks++;
        if (gap < 2 || gap > 5) begin
            errors++;
            $display("FAIL b2b_gap: got %0d clks expected 2..5", gap);
        end
        wait_done(1, 1000);
        chk("npff_frame_clks", done_cyc[1] - fall_cyc[1], 640);
        chk("np_done_count", done_cnt[1], 2);

        // reset during data bit 3, then a clean 0x3C frame
        write(0, 8'hC3);
        wait_fall(0, 100);
        step(64 * 4 + 20);
        reset = 1'b1;
        #1;
        chk("abort_txd", int'(txd[0]), 1);
        chk("abort_busy", int'(busy[0]), 0);
        step(2);
        reset = 1'b0;
        chk("abort_baud_reset", int'(bout[0]), 0);
        step(50);
        chk("abort_no_done", done_cnt[0], 2);
        write(0, 8'h3C);
        wait_done(0, 1000);
        chk("x3c_frame_clks", done_cyc[0] - fall_cyc[0], 704);
        chk("x3c_done_count", done_cnt[0], 3);

        // tick held high: 16 clks per bit
        tick_period = 1;
        step(3);
        write(0, 8'h96);
        wait_done(0, 400);
        chk("t1_frame_clks", done_cyc[0] - fall_cyc[0], 176);
        chk("t1_done_count", done_cnt[0], 4);
        step(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
